// File: rtl/reg_scan_pkg.sv
// Shared definitions for the register-display select sequencer.
//   NUM_REGS / SEL_W : number of viewable registers and select width.
//   scan_state_e     : sequencer state; its encoding doubles as the mode LED output.
//   next_sel()       : successor of the current select. When REG_SCAN_SKIP_EN is defined it
//                      takes a skip mask and returns the nearest unmasked index after the
//                      current one, wrapping around. It returns the current index if every
//                      register is masked.
package reg_scan_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned SEL_W    = 3;

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    PAUSED = 2'b10
  } scan_state_e;

`ifdef REG_SCAN_SKIP_EN
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0]    cur,
                                                input logic [NUM_REGS-1:0] mask);
    logic [SEL_W-1:0] idx;
    logic             found;
    next_sel = cur;
    found    = 1'b0;
    // Search forward from cur+1. The final step wraps back to cur itself.
    for (int i = 1; i <= int'(NUM_REGS); i++) begin
      idx = cur + SEL_W'(i);
      if (!found && !mask[idx]) begin
        next_sel = idx;
        found    = 1'b1;
      end
    end
  endfunction
`else
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur);
    return SEL_W'((32'(cur) + 32'd1) % NUM_REGS);
  endfunction
`endif

endpackage

// File: rtl/btn_debounce.sv
// Step-button conditioner: a 2-flop synchronizer, a stable-cycle counter, the debounced
// level, and a registered one-cycle pulse on its rising edge.
//   clk_i   : system clock
//   rst_i   : synchronous active-high reset; this also discards any partial count
//   btn_i   : raw button, asynchronous and bouncy
//   pulse_o : one-cycle pulse, one cycle after the debounced level rises
// The level flips only after DEBOUNCE_CYCLES consecutive cycles in which the synchronized
// input differs from it. Any agreeing cycle restarts the count.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_dly_q, level_dly_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    sync1_d     = btn_i;
    sync2_d     = sync1_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    level_dly_d = level_q;
    pulse_d     = level_q & ~level_dly_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/reg_scan_ctrl.sv
// Display-select sequencer for the register viewer.
//   Clock    : system clock, rising edge
//   Reset    : synchronous active-high reset
//   SW       : manual register select
//   auto_en  : 1 = automatic scan, 0 = manual
//   pause    : freezes the dwell timer while scanning
//   step_btn : raw step button (asynchronous, bouncy)
//   skip_mask: present only with REG_SCAN_SKIP_EN; bit i=1 skips Ri in scan/step
//   sel      : registered select to the display mux
//   adv      : one-cycle pulse, high on the first cycle that a scanned/stepped sel is visible
//   mode     : 00 MANUAL, 01 AUTO, 10 PAUSED
// Build option: define REG_SCAN_SKIP_EN to add the skip_mask input.
module reg_scan_ctrl
  import reg_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [SEL_W-1:0] SW,
  input  logic             auto_en,
  input  logic             pause,
  input  logic             step_btn,
`ifdef REG_SCAN_SKIP_EN
  input  logic [7:0]       skip_mask,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             adv,
  output logic [1:0]       mode
);

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
  localparam logic [DwellW-1:0] DwellMax = DwellW'(DWELL_CYCLES - 1);

  scan_state_e       state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DwellW-1:0] cnt_q, cnt_d;
  logic              adv_q, adv_d;
  logic              step_pulse;
  logic              do_adv;
  logic [SEL_W-1:0]  nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .btn_i  (step_btn),
    .pulse_o(step_pulse)
  );

`ifdef REG_SCAN_SKIP_EN
  assign nxt = next_sel(sel_q, skip_mask);
`else
  assign nxt = next_sel(sel_q);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    adv_d   = 1'b0;
    do_adv  = 1'b0;
    if (!auto_en) begin
      // Manual takes priority over any advance due on this cycle.
      state_d = MANUAL;
      sel_d   = SW;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        MANUAL: begin
          // Entering the scan keeps the current select and starts a fresh dwell.
          state_d = AUTO;
          cnt_d   = '0;
        end
        AUTO: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (cnt_q == DwellMax) begin
            do_adv = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PAUSED: begin
          if (!pause) begin
            state_d = AUTO;
          end
        end
        default: begin
          state_d = MANUAL;
        end
      endcase
      // A step coinciding with an expiry merges into a single advance.
      if (step_pulse && (state_q != MANUAL)) begin
        do_adv = 1'b1;
        cnt_d  = '0;
      end
      // With every register masked, the successor is sel itself: hold and no adv.
      if (do_adv && (nxt != sel_q)) begin
        sel_d = nxt;
        adv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= MANUAL;
      sel_q   <= '0;
      cnt_q   <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
    end
  end

  assign sel  = sel_q;
  assign adv  = adv_q;
  assign mode = state_q;

endmodule
